// File: rtl/shift_reg4_universal_pkg.sv
// Shared types and constants for the 4-bit universal shift register.
package shift_reg4_universal_pkg;

  // Register width is fixed for this part.
  localparam int unsigned Width = 4;

  // Power event lines: Q[0..3] rise events, then S_OUT rise event.
  localparam int unsigned PwrBits = Width + 1;

  typedef enum logic [1:0] {
    ModeShr  = 2'b00,
    ModeShl  = 2'b01,
    ModeRot  = 2'b10,
    ModeLoad = 2'b11
  } modo_e;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLoaded = 1'b1
  } load_st_e;

endpackage

// File: rtl/shift_reg4_universal_if.sv
// Control, data and power-event bundle for the universal shift register.
interface shift_reg4_universal_if;
  import shift_reg4_universal_pkg::*;

  logic               enb;
  modo_e              modo;
  logic               s_in_r;
  logic               s_in_l;
  logic [Width-1:0]   d;
  logic [Width-1:0]   q;
  logic               s_out;
  logic               load_done;
  // One-cycle pulse per 0->1 transition, for the external power counters.
  logic [PwrBits-1:0] pwr_evt;

  modport master (
    output enb, modo, s_in_r, s_in_l, d,
    input  q, s_out, load_done, pwr_evt
  );

  modport slave (
    input  enb, modo, s_in_r, s_in_l, d,
    output q, s_out, load_done, pwr_evt
  );

endinterface

// File: rtl/shift_reg4_universal_dff_r.sv
// Single D flip-flop with enable, async active-high clear and rise-event hook.
module shift_reg4_universal_dff_r (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic q_q;
  logic rise_q;

  // Capture on enabled edges; flag a rise only for a real 0->1 change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      rise_q <= en_i & d_i & ~q_q;
      if (en_i) begin
        q_q <= d_i;
      end
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/shift_reg4_universal.sv
// 4-bit universal shift register: shift right/left, rotate right, parallel load.
module shift_reg4_universal
  import shift_reg4_universal_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  shift_reg4_universal_if.slave bus
);

  logic [Width-1:0] q;
  logic [Width-1:0] q_d;
  logic [Width-1:0] q_rise;
  logic             s_out_q, s_out_d;
  logic             s_rise_q;
  load_st_e         st_q, st_d;

  // Per-bit next-state source selected by the operation; X mode poisons Q.
  always_comb begin
    q_d     = q;
    s_out_d = s_out_q;
    case (bus.modo)
      ModeShr: begin
        q_d     = {bus.s_in_r, q[Width-1:1]};
        s_out_d = q[0];
      end
      ModeShl: begin
        q_d     = {q[Width-2:0], bus.s_in_l};
        s_out_d = q[Width-1];
      end
      ModeRot: begin
        q_d     = {q[0], q[Width-1:1]};
        s_out_d = q[0];
      end
      ModeLoad: begin
        q_d     = bus.d;
        s_out_d = 1'b0;
      end
      default: begin
        q_d     = 'x;
        s_out_d = 1'bx;
      end
    endcase
  end

  for (genvar i = 0; i < Width; i++) begin : g_bit
    shift_reg4_universal_dff_r u_dff (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (bus.enb),
      .d_i    (q_d[i]),
      .q_o    (q[i]),
      .rise_o (q_rise[i])
    );
  end

  // Serial output register with its own rise-event flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_out_q  <= 1'b0;
      s_rise_q <= 1'b0;
    end else begin
      s_rise_q <= bus.enb & s_out_d & ~s_out_q;
      if (bus.enb) begin
        s_out_q <= s_out_d;
      end
    end
  end

  // Load tracker state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  // Any edge without an enabled load returns the tracker to idle.
  always_comb begin
    st_d = StIdle;
    if (bus.enb && (bus.modo == ModeLoad)) begin
      st_d = StLoaded;
    end
  end

  assign bus.q         = q;
  assign bus.s_out     = s_out_q;
  assign bus.load_done = (st_q == StLoaded);
  assign bus.pwr_evt   = {s_rise_q, q_rise};

endmodule

// File: tb/tb_shift_reg4_universal.sv
// Self-checking bench: directed vector table, corner sequences, random vs model.
module tb_shift_reg4_universal;
  import shift_reg4_universal_pkg::*;

  localparam int PwrC = 8;

  typedef struct {
    logic       enb;
    logic [1:0] modo;
    logic       sinr;
    logic       sinl;
    logic [3:0] d;
    logic [3:0] eq;
    logic       es;
    logic       eld;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   pwr_cntr [0:15];

  shift_reg4_universal_if bus ();

  shift_reg4_universal dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge, then sample and accumulate power events.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < PwrBits; i++) begin
      if (bus.pwr_evt[i] === 1'b1) pwr_cntr[PwrC + i]++;
    end
  endtask

  task automatic drive(input logic enb, input logic [1:0] modo, input logic sinr,
                       input logic sinl, input logic [3:0] d);
    bus.enb    = enb;
    bus.modo   = modo_e'(modo);
    bus.s_in_r = sinr;
    bus.s_in_l = sinl;
    bus.d      = d;
  endtask

  vec_t vq[$];
  int   base [0:4];

  initial begin
    int mq, ms, mld, nq, ns;
    int mp [0:4];
    logic       r_enb;
    logic [1:0] r_modo;
    logic       r_sinr, r_sinl;
    logic [3:0] r_d;

    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) pwr_cntr[i] = 0;
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
    #12 rst = 1'b0;
    #1;
    chk("reset_q", bus.q, 4'h0);
    chk("reset_sout", bus.s_out, 1'b0);
    chk("reset_ld", bus.load_done, 1'b0);

    //                 enb modo   sinr sinl d        q        s_out ld
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0});
    vq.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0});
    // Back-to-back loads keep LOAD_DONE high.
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b0111, 4'b0111, 1'b0, 1'b1});
    vq.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0});
    // Hold: Q and S_OUT frozen.
    vq.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0});
    vq.push_back('{1'b0, 2'b01, 1'b1, 1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0});
    vq.push_back('{1'b0, 2'b11, 1'b1, 1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0});
    // Disabled edge right after a load clears LOAD_DONE.
    vq.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b1});
    vq.push_back('{1'b0, 2'b11, 1'b0, 1'b0, 4'b1010, 4'b0101, 1'b0, 1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      int snap [0:4];
      for (int b = 0; b < 5; b++) snap[b] = pwr_cntr[PwrC + b];
      drive(vq[i].enb, vq[i].modo, vq[i].sinr, vq[i].sinl, vq[i].d);
      step();
      chk($sformatf("vec%0d_q", i), bus.q, vq[i].eq);
      chk($sformatf("vec%0d_sout", i), bus.s_out, vq[i].es);
      chk($sformatf("vec%0d_ld", i), bus.load_done, vq[i].eld);
      if (!vq[i].enb) begin
        for (int b = 0; b < 5; b++)
          chk($sformatf("vec%0d_pwr_hold%0d", i, b), pwr_cntr[PwrC + b], snap[b]);
      end
    end

    // Async reset mid-cycle, no clock edge required.
    drive(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
    step();
    chk("pre_rst_q", bus.q, 4'b1011);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 4'b0000);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_q", bus.q, 4'h0);
    chk("async_rst_sout", bus.s_out, 1'b0);
    chk("async_rst_ld", bus.load_done, 1'b0);
    step();
    chk("held_rst_q", bus.q, 4'h0);
    #4 rst = 1'b0;
    step();
    chk("post_rst_shr_q", bus.q, 4'b1000);
    chk("post_rst_shr_sout", bus.s_out, 1'b0);

    // Power count: 0000,1111,0000,1111 loads.
    for (int b = 0; b < 5; b++) base[b] = pwr_cntr[PwrC + b];
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 1'b0, 1'b0, (k % 2 == 0) ? 4'b0000 : 4'b1111);
      step();
    end
    for (int b = 0; b < 4; b++)
      chk($sformatf("pwr_q%0d_delta", b), pwr_cntr[PwrC + b] - base[b], 2);
    chk("pwr_sout_delta", pwr_cntr[PwrC + 4] - base[4], 0);

    // Random phase against an arithmetic model, starting from reset.
    #4 rst = 1'b1;
    #6 rst = 1'b0;
    mq = 0; ms = 0; mld = 0;
    for (int b = 0; b < 5; b++) begin
      mp[b] = 0;
      base[b] = pwr_cntr[PwrC + b];
    end
    for (int n = 0; n < 300; n++) begin
      r_enb  = ($urandom_range(0, 3) != 0);
      r_modo = 2'($urandom_range(0, 3));
      r_sinr = 1'($urandom_range(0, 1));
      r_sinl = 1'($urandom_range(0, 1));
      r_d    = 4'($urandom_range(0, 15));
      drive(r_enb, r_modo, r_sinr, r_sinl, r_d);
      step();
      if (r_enb) begin
        case (r_modo)
          2'd0: begin nq = (int'(r_sinr) * 8) + (mq / 2); ns = mq % 2; end
          2'd1: begin nq = ((mq * 2) % 16) + int'(r_sinl); ns = mq / 8; end
          2'd2: begin nq = ((mq % 2) * 8) + (mq / 2); ns = mq % 2; end
          default: begin nq = int'(r_d); ns = 0; end
        endcase
        mld = (r_modo == 2'd3) ? 1 : 0;
      end else begin
        nq = mq; ns = ms; mld = 0;
      end
      for (int b = 0; b < 4; b++)
        if (((nq >> b) & 1) == 1 && ((mq >> b) & 1) == 0) mp[b]++;
      if (ns == 1 && ms == 0) mp[4]++;
      mq = nq; ms = ns;
      chk($sformatf("rnd%0d_q", n), bus.q, mq);
      chk($sformatf("rnd%0d_sout", n), bus.s_out, ms);
      chk($sformatf("rnd%0d_ld", n), bus.load_done, mld);
    end
    for (int b = 0; b < 5; b++)
      chk($sformatf("rnd_pwr%0d", b), pwr_cntr[PwrC + b] - base[b], mp[b]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
